// File: rtl/spi_reg_access_ctrl_if.sv
// Host-side request/response channel of the SPI register access controller.
// The host drives the master modport and the controller the slave modport.
interface spi_reg_access_ctrl_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int REG_WIDTH  = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [REG_WIDTH-1:0]  req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [REG_WIDTH-1:0]  rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/spi_reg_access_ctrl.sv
// Turns single host register reads/writes into one SPI master frame each,
// with a bounded wait for frame completion and a held response.
module spi_reg_access_ctrl #(
    parameter int ADDR_WIDTH     = 7,
    parameter int REG_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                            clk,
    input  logic                            rstn,
    spi_reg_access_ctrl_if.slave            host,
    output logic                            spi_begin,
    input  logic                            spi_is_busy,
    output logic [ADDR_WIDTH+REG_WIDTH:0]   spi_master_tx_data,
    input  logic [ADDR_WIDTH+REG_WIDTH:0]   spi_master_rx_data,
    input  logic                            spi_master_rx_data_valid
);
    localparam int FW    = 1 + ADDR_WIDTH + REG_WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WAIT_FREE, START, XFER, RESP} state_t;

    state_t           state;
    logic             is_wr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             unused_rx_hi;

    // Top bit is the read flag; read frames carry zero in the data field.
    function automatic logic [FW-1:0] build_frame(input logic                  wr,
                                                  input logic [ADDR_WIDTH-1:0] addr,
                                                  input logic [REG_WIDTH-1:0]  wdata);
        return {~wr, addr, (wr ? wdata : {REG_WIDTH{1'b0}})};
    endfunction

    assign cnt_nxt      = cnt + CNT_W'(1);
    assign unused_rx_hi = ^spi_master_rx_data[FW-1:REG_WIDTH];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state              <= IDLE;
            is_wr              <= 1'b0;
            cnt                <= '0;
            host.req_ready     <= 1'b0;
            host.rsp_valid     <= 1'b0;
            host.rsp_rdata     <= '0;
            host.rsp_err       <= 1'b0;
            spi_begin          <= 1'b0;
            spi_master_tx_data <= '0;
        end else begin
            spi_begin <= 1'b0;
            case (state)
                IDLE: begin
                    host.req_ready <= 1'b1;
                    if (host.req_valid && host.req_ready) begin
                        host.req_ready     <= 1'b0;
                        spi_master_tx_data <= build_frame(host.req_wr, host.req_addr,
                                                          host.req_wdata);
                        is_wr              <= host.req_wr;
                        state              <= WAIT_FREE;
                    end
                end
                WAIT_FREE: begin
                    if (!spi_is_busy) begin
                        spi_begin <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= XFER;
                end
                XFER: begin
                    cnt <= cnt_nxt;
                    // A frame completing on the expiry cycle still counts as a success.
                    if (spi_master_rx_data_valid) begin
                        host.rsp_valid <= 1'b1;
                        host.rsp_err   <= 1'b0;
                        host.rsp_rdata <= is_wr ? '0 : spi_master_rx_data[REG_WIDTH-1:0];
                        state          <= RESP;
                    end else if (cnt_nxt >= CNT_LAST) begin
                        host.rsp_valid <= 1'b1;
                        host.rsp_err   <= 1'b1;
                        host.rsp_rdata <= '0;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (host.rsp_ready) begin
                        host.rsp_valid <= 1'b0;
                        host.rsp_err   <= 1'b0;
                        host.rsp_rdata <= '0;
                        host.req_ready <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_reg_access_ctrl.sv
// Directed bench for spi_reg_access_ctrl: the bench plays host and SPI master,
// expected responses are queued at request time and compared on rsp_valid.
module tb_spi_reg_access_ctrl;
    localparam int AW = 7;
    localparam int RW = 8;
    localparam int FW = 1 + AW + RW;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          spi_begin;
    logic          spi_is_busy;
    logic [FW-1:0] tx_data;
    logic [FW-1:0] rx_data;
    logic          rx_valid;

    always #5 clk = ~clk;

    spi_reg_access_ctrl_if #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) hif ();

    spi_reg_access_ctrl #(
        .ADDR_WIDTH    (AW),
        .REG_WIDTH     (RW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                     (clk),
        .rstn                    (rstn),
        .host                    (hif),
        .spi_begin               (spi_begin),
        .spi_is_busy             (spi_is_busy),
        .spi_master_tx_data      (tx_data),
        .spi_master_rx_data      (rx_data),
        .spi_master_rx_data_valid(rx_valid)
    );

    typedef struct packed {
        logic [RW-1:0] rdata;
        logic          err;
    } rsp_t;

    rsp_t sb[$];
    int   passed    = 0;
    int   total     = 0;
    int   begin_cnt = 0;

    always @(negedge clk) if (spi_begin === 1'b1) begin_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, hif.req_ready, 0);
        chk({tag, "_rsp_valid"}, hif.rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, hif.rsp_rdata, 0);
        chk({tag, "_rsp_err"},   hif.rsp_err,   0);
        chk({tag, "_spi_begin"}, spi_begin,     0);
        chk({tag, "_tx_data"},   tx_data,       0);
    endtask

    // Leaves the bench one cycle after the acceptance edge.
    task automatic accept(input logic wr, input logic [AW-1:0] addr, input logic [RW-1:0] wdata);
        bit seen = 1'b0;
        hif.req_wr    = wr;
        hif.req_addr  = addr;
        hif.req_wdata = wdata;
        hif.req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (hif.req_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("req_ready_wait", {31'b0, seen}, 1);
        step();
        hif.req_valid = 1'b0;
    endtask

    // From the first WAIT_FREE cycle with busy low: begin must fire the next cycle only.
    task automatic begin_seq();
        @(negedge clk);
        chk("begin_early", spi_begin, 0);
        step();
        @(negedge clk);
        chk("begin_pulse", spi_begin, 1);
        step();
    endtask

    task automatic pulse_rx(input logic [FW-1:0] frame);
        rx_data  = frame;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic finish_resp(input int hold, input bit stray);
        rsp_t          e;
        logic [FW-1:0] tx0;
        tx0 = tx_data;
        @(negedge clk);
        chk("rsp_valid", hif.rsp_valid, 1);
        chk("sb_pending", {31'b0, sb.size() > 0}, 1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk("rsp_rdata", hif.rsp_rdata, e.rdata);
        chk("rsp_err",   hif.rsp_err,   e.err);
        for (int i = 0; i < hold; i++) begin
            step();
            if (stray) begin
                rx_data  = 16'hA5A5 ^ FW'(i);
                rx_valid = (i % 2 == 0);
            end
            @(negedge clk);
            chk("hold_rsp_valid", hif.rsp_valid, 1);
            chk("hold_rsp_rdata", hif.rsp_rdata, e.rdata);
            chk("hold_tx_data",   tx_data,       tx0);
            chk("hold_req_ready", hif.req_ready, 0);
        end
        rx_valid      = 1'b0;
        hif.rsp_ready = 1'b1;
        step();
        hif.rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_drop",       hif.rsp_valid, 0);
        chk("req_ready_back", hif.req_ready, 1);
        step();
    endtask

    initial begin
        int b0;
        int k;
        rx_valid      = 1'b0;
        rx_data       = '0;
        spi_is_busy   = 1'b0;
        hif.req_valid = 1'b0;
        hif.req_wr    = 1'b0;
        hif.req_addr  = '0;
        hif.req_wdata = '0;
        hif.rsp_ready = 1'b0;

        repeat (3) step();
        @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        step();
        @(negedge clk);
        chk("ready_after_reset", hif.req_ready, 1);
        step();

        // Write 0x12 <- 0x5A; returned frame bits must not leak into a write response
        b0 = begin_cnt;
        sb.push_back('{rdata: 8'h00, err: 1'b0});
        accept(1'b1, 7'h12, 8'h5A);
        chk("wr_tx_data", tx_data, 16'h125A);
        chk("ready_low_busy", hif.req_ready, 0);
        begin_seq();
        pulse_rx(16'hBEEF);
        finish_resp(0, 1'b0);
        chk("wr_begin_count", begin_cnt - b0, 1);

        // Read 0x05, wdata is ignored
        b0 = begin_cnt;
        sb.push_back('{rdata: 8'hC3, err: 1'b0});
        accept(1'b0, 7'h05, 8'h77);
        chk("rd_tx_data", tx_data, 16'h8500);
        begin_seq();
        pulse_rx(16'h00C3);
        finish_resp(0, 1'b0);
        chk("rd_begin_count", begin_cnt - b0, 1);

        // Master busy for 20 cycles after acceptance, stray rx pulse while waiting
        b0 = begin_cnt;
        spi_is_busy = 1'b1;
        sb.push_back('{rdata: 8'h42, err: 1'b0});
        accept(1'b0, 7'h2A, 8'h00);
        chk("busy_tx_data", tx_data, 16'hAA00);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("busy_no_begin", spi_begin, 0);
            step();
            rx_data  = 16'h1234;
            rx_valid = (i == 5);
        end
        rx_valid    = 1'b0;
        spi_is_busy = 1'b0;
        begin_seq();
        pulse_rx(16'h0042);
        finish_resp(0, 1'b0);
        chk("busy_begin_count", begin_cnt - b0, 1);

        // No frame completion: error response TO cycles after the begin pulse
        sb.push_back('{rdata: 8'h00, err: 1'b1});
        accept(1'b0, 7'h7F, 8'h00);
        chk("to_tx_data", tx_data, 16'hFF00);
        begin_seq();
        k = 0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (hif.rsp_valid === 1'b1) begin
                k = j;
                break;
            end
            step();
        end
        chk("timeout_latency", k, TO);
        finish_resp(0, 1'b0);

        // Next request after a timeout behaves normally
        sb.push_back('{rdata: 8'h00, err: 1'b0});
        accept(1'b1, 7'h01, 8'hFF);
        chk("post_to_tx_data", tx_data, 16'h01FF);
        begin_seq();
        pulse_rx(16'h0000);
        finish_resp(0, 1'b0);

        // Frame completes on the expiry cycle: success wins
        sb.push_back('{rdata: 8'h5C, err: 1'b0});
        accept(1'b0, 7'h33, 8'h00);
        chk("race_tx_data", tx_data, 16'hB300);
        begin_seq();
        repeat (TO - 2) step();
        pulse_rx(16'h005C);
        finish_resp(0, 1'b0);

        // Host stalls the response for 10 cycles with stray rx pulses in RESP
        sb.push_back('{rdata: 8'h66, err: 1'b0});
        accept(1'b0, 7'h40, 8'h00);
        chk("stall_tx_data", tx_data, 16'hC000);
        begin_seq();
        step();
        step();
        pulse_rx(16'h9966);
        finish_resp(10, 1'b1);

        // Reset during XFER, then a late rx pulse must not produce a response
        b0 = begin_cnt;
        accept(1'b0, 7'h11, 8'h00);
        begin_seq();
        step();
        rstn = 1'b0;
        step();
        @(negedge clk);
        check_all_zero("midreset");
        step();
        rstn = 1'b1;
        pulse_rx(16'h00EE);
        @(negedge clk);
        chk("midreset_ready", hif.req_ready, 1);
        chk("midreset_no_rsp", hif.rsp_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("late_rx_ignored", hif.rsp_valid, 0);
        end
        chk("midreset_begin_count", begin_cnt - b0, 1);
        step();

        // Normal write after the abort
        sb.push_back('{rdata: 8'h00, err: 1'b0});
        accept(1'b1, 7'h7E, 8'h3C);
        chk("final_tx_data", tx_data, 16'h7E3C);
        begin_seq();
        pulse_rx(16'hFFFF);
        finish_resp(0, 1'b0);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
